// File: rtl/instr_decode_stage.sv
// Decode stage with a 2-entry skid buffer: 1-cycle latency, stalls on !dc_ready, halts after func dne.
// Optional: define DECODE_ILLEGAL_CHK_EN to add the dc_illegal flag output.
module instr_decode_stage #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [8:0]      if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  output logic            dc_valid,
  input  logic            dc_ready,
  output logic [4:0]      dc_opcode,
  output logic [3:0]      dc_dst,
  output logic [3:0]      dc_src,
  output logic [4:0]      dc_rop,
  output logic            dc_sel,
  output logic [PC_W-1:0] dc_pc,
  output logic            dc_halt,
  output logic            halted
`ifdef DECODE_ILLEGAL_CHK_EN
  ,
  output logic            dc_illegal
`endif
);

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  typedef struct packed {
    logic [4:0]      opcode;
    logic [3:0]      dst;
    logic [3:0]      src;
    logic [4:0]      rop;
    logic            sel;
    logic [PC_W-1:0] pc;
    logic            halt;
`ifdef DECODE_ILLEGAL_CHK_EN
    logic            illegal;
`endif
  } entry_t;

  state_t state, state_nxt;
  entry_t dec, out_dat, sk_dat;
  logic   out_vld, sk_vld;
  logic   accept, consume, flush_eff;
  logic [4:0] op;
  logic [3:0] opd;

  assign op        = if_instr[8:4];
  assign opd       = if_instr[3:0];
  assign if_ready  = rst_n && !sk_vld && (state == RUN);
  assign accept    = if_valid && if_ready;
  assign consume   = out_vld && dc_ready;
  assign flush_eff = flush && (state != HALTED);

  // Decode happens at accept so the output register holds fully decoded fields.
  always_comb begin
    dec        = '0;
    dec.opcode = op;
    dec.src    = opd;
    dec.dst    = opd;
    dec.sel    = op[0];
    dec.pc     = if_pc;
    dec.halt   = (op == 5'b11111) && (opd == 4'b1111);
`ifdef DECODE_ILLEGAL_CHK_EN
    dec.illegal = (op == 5'b11111) &&
                  (((opd >= 4'd4) && (opd <= 4'd11)) || (opd == 4'd14));
`endif
    if (!op[4]) begin
      if (op[3:1] == 3'b000) begin
        dec.rop = op[0] ? 5'd5 : 5'd4;
      end else begin
        dec.rop = 5'd6;
        dec.dst = op[3:0];
      end
    end else if (!op[3]) begin
      dec.rop = {2'b01, op[2:0]};
    end else begin
      case (op[2:0])
        3'b000:  dec.rop = 5'd0;
        3'b001:  dec.rop = 5'd17;
        3'b010:  dec.rop = 5'd1;
        3'b011:  dec.rop = 5'd1;
        3'b100:  dec.rop = 5'd20;
        3'b101:  dec.rop = 5'd21;
        3'b110:  dec.rop = 5'd22;
        default: dec.rop = (opd[3:2] == 2'b00) ? {3'b110, opd[1:0]} : 5'd23;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (accept && !flush && dec.halt) state_nxt = HALT_PEND;
      HALT_PEND: begin
        if (flush)                          state_nxt = RUN;
        else if (consume && out_dat.halt)   state_nxt = HALTED;
      end
      HALTED:    state_nxt = HALTED;
      default:   state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      out_vld <= 1'b0;
      sk_vld  <= 1'b0;
      out_dat <= '0;
      sk_dat  <= '0;
    end else begin
      state <= state_nxt;
      if (flush_eff) begin
        out_vld <= 1'b0;
        sk_vld  <= 1'b0;
      end else if (!out_vld || consume) begin
        // Skid entry is older than anything arriving, so it refills the output first.
        if (sk_vld) begin
          out_dat <= sk_dat;
          out_vld <= 1'b1;
          sk_vld  <= 1'b0;
        end else begin
          out_vld <= accept;
          if (accept) out_dat <= dec;
        end
      end else if (accept) begin
        sk_dat <= dec;
        sk_vld <= 1'b1;
      end
    end
  end

  assign dc_valid  = out_vld;
  assign dc_opcode = out_dat.opcode;
  assign dc_dst    = out_dat.dst;
  assign dc_src    = out_dat.src;
  assign dc_rop    = out_dat.rop;
  assign dc_sel    = out_dat.sel;
  assign dc_pc     = out_dat.pc;
  assign dc_halt   = out_dat.halt;
  assign halted    = (state == HALTED);
`ifdef DECODE_ILLEGAL_CHK_EN
  assign dc_illegal = out_dat.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode values, skid/stall, flush and halt sequencing.
module tb_instr_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n, if_valid, if_ready, flush, dc_valid, dc_ready;
  logic [8:0] if_instr;
  logic [7:0] if_pc, dc_pc;
  logic [4:0] dc_opcode, dc_rop;
  logic [3:0] dc_dst, dc_src;
  logic       dc_sel, dc_halt, halted;
`ifdef DECODE_ILLEGAL_CHK_EN
  logic       dc_illegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .flush(flush),
    .dc_valid(dc_valid), .dc_ready(dc_ready),
    .dc_opcode(dc_opcode), .dc_dst(dc_dst), .dc_src(dc_src), .dc_rop(dc_rop),
    .dc_sel(dc_sel), .dc_pc(dc_pc), .dc_halt(dc_halt), .halted(halted)
`ifdef DECODE_ILLEGAL_CHK_EN
    , .dc_illegal(dc_illegal)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] instr, input logic [7:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; dc_ready = 1'b0;
    tick(); tick();
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_dc_valid", 32'(dc_valid), 32'd0);
    chk("rst_halted",   32'(halted),   32'd0);
    chk("rst_opcode",   32'(dc_opcode), 32'd0);
    chk("rst_rop",      32'(dc_rop),   32'd0);
    chk("rst_pc",       32'(dc_pc),    32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_if_ready", 32'(if_ready), 32'd1);

    // movd: mov group takes dst from opcode[3:0]
    dc_ready = 1'b1;
    send(9'b00011_0110, 8'd5);
    tick();
    if_valid = 1'b0;
    chk("movd_valid", 32'(dc_valid), 32'd1);
    chk("movd_dst",   32'(dc_dst),   32'd3);
    chk("movd_src",   32'(dc_src),   32'd6);
    chk("movd_rop",   32'(dc_rop),   32'd6);
    chk("movd_pc",    32'(dc_pc),    32'd5);
    tick();
    chk("movd_drain", 32'(dc_valid), 32'd0);

    // Back-to-back with a 3-cycle stall
    dc_ready = 1'b0;
    send(9'b00000_0001, 8'd10);
    tick();
    chk("bb_a_out", 32'(dc_pc), 32'd10);
    send(9'b00001_0010, 8'd11);
    chk("bb_rdy_b", 32'(if_ready), 32'd1);
    tick();
    send(9'b10000_0011, 8'd12);
    chk("bb_full_rdy", 32'(if_ready), 32'd0);
    tick();
    tick();
    chk("bb_stall_valid", 32'(dc_valid), 32'd1);
    chk("bb_stall_pc",    32'(dc_pc),    32'd10);
    chk("bb_stall_rop",   32'(dc_rop),   32'd4);
    chk("bb_stall_rdy",   32'(if_ready), 32'd0);
    dc_ready = 1'b1;
    tick();
    chk("bb_b_pc",  32'(dc_pc),  32'd11);
    chk("bb_b_rop", 32'(dc_rop), 32'd5);
    chk("bb_c_rdy", 32'(if_ready), 32'd1);
    tick();
    send(9'b11000_0100, 8'd13);
    chk("bb_c_valid", 32'(dc_valid), 32'd1);
    chk("bb_c_pc",    32'(dc_pc),    32'd12);
    chk("bb_c_rop",   32'(dc_rop),   32'd8);
    tick();
    if_valid = 1'b0;
    chk("bb_d_valid", 32'(dc_valid), 32'd1);
    chk("bb_d_pc",    32'(dc_pc),    32'd13);
    chk("bb_d_rop",   32'(dc_rop),   32'd0);
    tick();
    chk("bb_drain", 32'(dc_valid), 32'd0);

    // Decode table points
    send(9'b10110_0010, 8'd20);
    tick();
    chk("bizr_rop", 32'(dc_rop), 32'd14);
    chk("bizr_dst", 32'(dc_dst), 32'd2);
    send(9'b11111_0010, 8'd21);
    tick();
    chk("lj2_rop",  32'(dc_rop),  32'd26);
    chk("lj2_halt", 32'(dc_halt), 32'd0);
    send(9'b11011_1000, 8'd22);
    tick();
    chk("mths_rop", 32'(dc_rop), 32'd1);
    chk("mths_sel", 32'(dc_sel), 32'd1);
    chk("mths_src", 32'(dc_src), 32'd8);
    send(9'b11111_0100, 8'd23);
    tick();
    if_valid = 1'b0;
    chk("ill_rop", 32'(dc_rop), 32'd23);
    chk("ill_pc",  32'(dc_pc),  32'd23);
`ifdef DECODE_ILLEGAL_CHK_EN
    chk("ill_flag", 32'(dc_illegal), 32'd1);
`endif
    tick();
    chk("dec_drain", 32'(dc_valid), 32'd0);

    // Flush with both entries full and a pending fetch
    dc_ready = 1'b0;
    send(9'b00100_0001, 8'd30);
    tick();
    send(9'b00101_0010, 8'd31);
    tick();
    chk("fl_full_rdy", 32'(if_ready), 32'd0);
    send(9'b00110_0011, 8'd32);
    flush = 1'b1;
    dc_ready = 1'b1;
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    chk("fl_valid0", 32'(dc_valid), 32'd0);
    chk("fl_rdy",    32'(if_ready), 32'd1);
    tick();
    chk("fl_valid1", 32'(dc_valid), 32'd0);
    // Same-cycle accept under flush is discarded
    send(9'b00111_0100, 8'd33);
    flush = 1'b1;
    #1;
    chk("fl_acc_rdy", 32'(if_ready), 32'd1);
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    chk("fl_acc_valid0", 32'(dc_valid), 32'd0);
    tick();
    chk("fl_acc_valid1", 32'(dc_valid), 32'd0);

    // dne then flush: back to RUN
    dc_ready = 1'b0;
    send(9'b11111_1111, 8'd40);
    tick();
    if_valid = 1'b0;
    chk("dne1_halt", 32'(dc_halt),  32'd1);
    chk("dne1_rop",  32'(dc_rop),   32'd23);
    chk("dne1_rdy",  32'(if_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("dne1_fl_valid",  32'(dc_valid), 32'd0);
    chk("dne1_fl_rdy",    32'(if_ready), 32'd1);
    chk("dne1_fl_halted", 32'(halted),   32'd0);

    // dne consumed: HALTED until reset
    send(9'b11111_1111, 8'd41);
    tick();
    send(9'b00010_0001, 8'd42);
    chk("dne2_halt", 32'(dc_halt), 32'd1);
    chk("dne2_pc",   32'(dc_pc),   32'd41);
    dc_ready = 1'b1;
    tick();
    chk("hlt_halted", 32'(halted),   32'd1);
    chk("hlt_valid",  32'(dc_valid), 32'd0);
    chk("hlt_rdy",    32'(if_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("hlt_fl_halted", 32'(halted),   32'd1);
    chk("hlt_fl_valid",  32'(dc_valid), 32'd0);
    chk("hlt_fl_rdy",    32'(if_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("hlt_rst_halted", 32'(halted),   32'd0);
    chk("hlt_rst_rdy",    32'(if_ready), 32'd0);
    chk("hlt_rst_valid",  32'(dc_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("hlt_rel_rdy", 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    chk("hlt_rel_pc", 32'(dc_pc), 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
